// File: rtl/mmio_responder_pkg.sv
// mmio_responder_pkg: shared constants and types for the MMIO responder.
//   WORD_LEN        data/address width
//   MMIO_BASE_ADDR  default window base (window is 32 bytes)
//   MMIO_OFF_*      word offsets (addr[4:2]) of the registers
//   MMIO_CTRL_*     bit positions inside CTRL
//   db_state_t      switch debounce FSM states
package mmio_responder_pkg;
    localparam int WORD_LEN = 32;
    localparam logic [WORD_LEN-1:0] MMIO_BASE_ADDR = 32'hFFFF_0000;
    localparam logic [2:0] MMIO_OFF_LED    = 3'd0;
    localparam logic [2:0] MMIO_OFF_SWVAL  = 3'd1;
    localparam logic [2:0] MMIO_OFF_SWCHG  = 3'd2;
    localparam logic [2:0] MMIO_OFF_TCOUNT = 3'd3;
    localparam logic [2:0] MMIO_OFF_TCMP   = 3'd4;
    localparam logic [2:0] MMIO_OFF_CTRL   = 3'd5;
    localparam int MMIO_CTRL_EN         = 0;
    localparam int MMIO_CTRL_MATCH      = 1;
    localparam int MMIO_CTRL_AUTORELOAD = 2;
    localparam int MMIO_CTRL_IRQ_EN     = 3;
    typedef enum logic {DB_IDLE, DB_COUNT} db_state_t;
endpackage

// File: rtl/mmio_responder_if.sv
// mmio_responder_if: CPU memory-stage data port as seen by the MMIO target.
//   mem_r_en  load request         mem_w_en  store request
//   addr      byte address         wdata     store data
//   rdata     load data (same cycle)   hit   address inside the window
interface mmio_responder_if;
    import mmio_responder_pkg::*;
    logic                mem_r_en;
    logic                mem_w_en;
    logic [WORD_LEN-1:0] addr;
    logic [WORD_LEN-1:0] wdata;
    logic [WORD_LEN-1:0] rdata;
    logic                hit;
    modport master (output mem_r_en, mem_w_en, addr, wdata, input rdata, hit);
    modport slave  (input mem_r_en, mem_w_en, addr, wdata, output rdata, hit);
endinterface

// File: rtl/mmio_responder_sw_debounce.sv
// mmio_responder_sw_debounce: 2-flop synchroniser plus word-wide debounce FSM.
//   clk, rst_n  clock, asynchronous active-low reset
//   sw          raw asynchronous switch inputs
//   swval       accepted (debounced) switch value
//   chg         one-cycle pulse of bits that changed on acceptance
module mmio_responder_sw_debounce
    import mmio_responder_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYC = 16'd50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WORD_LEN-1:0] sw,
    output logic [WORD_LEN-1:0] swval,
    output logic [WORD_LEN-1:0] chg
);
    logic [WORD_LEN-1:0] sync1, sync2, cand, cand_n, swval_n;
    logic [15:0] cnt, cnt_n;
    db_state_t state, state_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            cand  <= '0;
            swval <= '0;
            cnt   <= '0;
            state <= DB_IDLE;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            cand  <= cand_n;
            swval <= swval_n;
            cnt   <= cnt_n;
            state <= state_n;
        end
    end

    // A one-cycle debounce window accepts straight from IDLE; the counter
    // otherwise stops at DEBOUNCE_CYC-1 so it can never wrap.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        swval_n = swval;
        chg     = '0;
        if (state == DB_IDLE) begin
            if (sync2 != swval) begin
                if (DEBOUNCE_CYC == 16'd1) begin
                    swval_n = sync2;
                    chg     = sync2 ^ swval;
                end else begin
                    state_n = DB_COUNT;
                    cnt_n   = 16'd1;
                    cand_n  = sync2;
                end
            end
        end else if (sync2 != cand) begin
            cnt_n  = 16'd1;
            cand_n = sync2;
        end else if (sync2 == swval) begin
            state_n = DB_IDLE;
        end else if (cnt == DEBOUNCE_CYC - 16'd1) begin
            swval_n = cand;
            chg     = swval ^ cand;
            state_n = DB_IDLE;
        end else begin
            cnt_n = cnt + 16'd1;
        end
    end
endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: MMIO target with LED register, debounced switches and a compare timer.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         CPU data port (slave side): enables, address, store/load data, hit
//   sw          raw switch inputs
//   led         LED drive register
//   timer_irq   CTRL.match & CTRL.irq_en
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter logic [WORD_LEN-1:0] BASE_ADDR    = MMIO_BASE_ADDR,
    parameter logic [15:0]         DEBOUNCE_CYC = 16'd50000
) (
    input  logic                clk,
    input  logic                rst_n,
    mmio_responder_if.slave     bus,
    input  logic [WORD_LEN-1:0] sw,
    output logic [WORD_LEN-1:0] led,
    output logic                timer_irq
);
    logic [WORD_LEN-1:0] delta, swval, chg, swchg, tcount, tcmp;
    logic [2:0] off;
    logic we, hit_cmp, en, match, arl, irq_en;

    mmio_responder_sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .sw   (sw),
        .swval(swval),
        .chg  (chg)
    );

    assign delta     = bus.addr - BASE_ADDR;
    assign bus.hit   = delta < WORD_LEN'(32);
    assign off       = delta[4:2];
    assign we        = bus.mem_w_en & bus.hit;
    assign hit_cmp   = en & (tcount == tcmp);
    assign timer_irq = match & irq_en;

    // Hardware set events take priority over W1C; CPU writes override the timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led    <= '0;
            swchg  <= '0;
            tcount <= '0;
            tcmp   <= '1;
            en     <= 1'b0;
            match  <= 1'b0;
            arl    <= 1'b0;
            irq_en <= 1'b0;
        end else begin
            if (we && off == MMIO_OFF_LED) led <= bus.wdata;
            if (we && off == MMIO_OFF_TCMP) tcmp <= bus.wdata;
            swchg  <= (swchg & ~(we && off == MMIO_OFF_SWCHG ? bus.wdata : '0)) | chg;
            tcount <= we && off == MMIO_OFF_TCOUNT ? bus.wdata :
                      en ? (hit_cmp && arl ? '0 : tcount + 1'b1) : tcount;
            match  <= hit_cmp | (match & ~(we && off == MMIO_OFF_CTRL && bus.wdata[MMIO_CTRL_MATCH]));
            if (we && off == MMIO_OFF_CTRL) begin
                en     <= bus.wdata[MMIO_CTRL_EN];
                arl    <= bus.wdata[MMIO_CTRL_AUTORELOAD];
                irq_en <= bus.wdata[MMIO_CTRL_IRQ_EN];
            end
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.mem_r_en && bus.hit) begin
            case (off)
                MMIO_OFF_LED:    bus.rdata = led;
                MMIO_OFF_SWVAL:  bus.rdata = swval;
                MMIO_OFF_SWCHG:  bus.rdata = swchg;
                MMIO_OFF_TCOUNT: bus.rdata = tcount;
                MMIO_OFF_TCMP:   bus.rdata = tcmp;
                MMIO_OFF_CTRL:   bus.rdata = {{(WORD_LEN-4){1'b0}}, irq_en, arl, match, en};
                default:         bus.rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed bench with a cycle-level reference model of the MMIO responder.
module tb_mmio_responder;
    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [31:0] sw = '0;
    logic [31:0] led;
    logic timer_irq;
    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    mmio_responder_if bus();

    mmio_responder #(.BASE_ADDR(BASE), .DEBOUNCE_CYC(16'(DEB))) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .sw       (sw),
        .led      (led),
        .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: registers as named in the register map, switch
    // acceptance expressed as "synchronised value held for DEB edges".
    logic [31:0] m_led, m_swval, m_swchg, m_tcount, m_tcmp, m_s1, m_s2, m_prev;
    logic m_en, m_match, m_arl, m_irqen;
    int m_run;
    logic [31:0] t_chg, t_cnt;
    logic t_w, t_hc;
    int t_o;

    function automatic logic m_hit(input logic [31:0] a);
        return a >= BASE && a <= BASE + 32'h1F;
    endfunction

    function automatic logic [31:0] m_reg(input int o);
        case (o)
            0: return m_led;
            1: return m_swval;
            2: return m_swchg;
            3: return m_tcount;
            4: return m_tcmp;
            5: return {28'b0, m_irqen, m_arl, m_match, m_en};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_led = 0; m_swval = 0; m_swchg = 0; m_tcount = 0; m_tcmp = 32'hFFFF_FFFF;
            m_s1 = 0; m_s2 = 0; m_prev = 0; m_run = 0;
            m_en = 0; m_match = 0; m_arl = 0; m_irqen = 0;
        end else begin
            t_w = bus.mem_w_en && m_hit(bus.addr);
            t_o = int'((bus.addr - BASE) >> 2);
            m_run = (m_s2 == m_prev) ? (m_run < 1000 ? m_run + 1 : m_run) : 1;
            m_prev = m_s2;
            t_chg = 0;
            if (m_run == DEB && m_s2 != m_swval) begin
                t_chg = m_s2 ^ m_swval;
                m_swval = m_s2;
            end
            m_s2 = m_s1;
            m_s1 = sw;
            t_hc = m_en && m_tcount == m_tcmp;
            t_cnt = (t_w && t_o == 3) ? bus.wdata :
                    m_en ? ((t_hc && m_arl) ? 32'h0 : m_tcount + 1) : m_tcount;
            if (t_w && t_o == 0) m_led = bus.wdata;
            if (t_w && t_o == 4) m_tcmp = bus.wdata;
            m_swchg = (m_swchg & ~((t_w && t_o == 2) ? bus.wdata : 32'h0)) | t_chg;
            m_match = t_hc || (m_match && !(t_w && t_o == 5 && bus.wdata[1]));
            if (t_w && t_o == 5) begin
                m_en = bus.wdata[0];
                m_arl = bus.wdata[2];
                m_irqen = bus.wdata[3];
            end
            m_tcount = t_cnt;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("hit", {31'b0, bus.hit}, {31'b0, m_hit(bus.addr)});
            chk("rdata", bus.rdata, (bus.mem_r_en && m_hit(bus.addr)) ? m_reg(int'((bus.addr - BASE) >> 2)) : 32'h0);
            chk("led", led, m_led);
            chk("irq", {31'b0, timer_irq}, {31'b0, m_match & m_irqen});
        end
    end

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        #1;
        bus.mem_r_en = r;
        bus.mem_w_en = w;
        bus.addr = a;
        bus.wdata = d;
    endtask

    task automatic wr(input logic [31:0] o, input logic [31:0] d);
        drive(1'b0, 1'b1, BASE + o, d);
    endtask

    task automatic rd_chk(input logic [31:0] o, input logic [31:0] exp, input string name);
        drive(1'b1, 1'b0, BASE + o, 32'h0);
        #1 chk(name, bus.rdata, exp);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        bit found;
        bus.mem_r_en = 0; bus.mem_w_en = 0; bus.addr = 0; bus.wdata = 0;
        #1 rst_n = 1'b0;
        chk_on = 1'b1;
        nop(2);
        @(negedge clk);
        #1 rst_n = 1'b1;
        rd_chk(32'h00, 32'h0, "rst_led");
        rd_chk(32'h10, 32'hFFFF_FFFF, "rst_tcmp");
        rd_chk(32'h14, 32'h0, "rst_ctrl");

        wr(32'h00, 32'hA5);
        rd_chk(32'h00, 32'hA5, "led_read");
        chk("led_port", led, 32'hA5);
        rd_chk(32'h1C, 32'h0, "reserved_read");
        drive(1'b1, 1'b0, BASE - 4, 32'h0);
        #1 chk("below_hit", {31'b0, bus.hit}, 32'h0);
        chk("below_rdata", bus.rdata, 32'h0);
        drive(1'b1, 1'b1, BASE, 32'h5A);
        #1 chk("rw_prewrite", bus.rdata, 32'hA5);
        rd_chk(32'h00, 32'h5A, "rw_committed");

        sw = 32'h3;
        nop(4);
        rd_chk(32'h04, 32'h0, "swval_early");
        rd_chk(32'h04, 32'h3, "swval_at6");
        rd_chk(32'h08, 32'h3, "swchg_set");
        rd_chk(32'h08, 32'h3, "swchg_no_clr_on_read");
        for (int i = 0; i < 6; i++) begin
            sw = (i % 2 == 0) ? 32'hC : 32'h3;
            nop(2);
        end
        nop(3);
        rd_chk(32'h04, 32'h3, "swval_bounce");
        rd_chk(32'h08, 32'h3, "swchg_bounce");
        wr(32'h08, 32'h1);
        rd_chk(32'h08, 32'h2, "swchg_w1c");

        wr(32'h10, 32'd10);
        wr(32'h0C, 32'h0);
        wr(32'h14, 32'hD);
        found = 1'b0;
        for (int i = 1; i <= 30 && !found; i++) begin
            drive(1'b1, 1'b0, BASE + 32'h0C, 32'h0);
            #1;
            if (timer_irq) begin
                found = 1'b1;
                chk("irq_latency", 32'(i), 32'd12);
                chk("reload_zero", bus.rdata, 32'h0);
            end
        end
        if (!found) chk("irq_seen", {31'b0, found}, 32'h1);
        nop(9);
        wr(32'h14, 32'hF);
        rd_chk(32'h14, 32'hF, "match_set_wins");
        chk("irq_held", {31'b0, timer_irq}, 32'h1);
        wr(32'h14, 32'hF);
        rd_chk(32'h14, 32'hD, "match_w1c");
        wr(32'h14, 32'h0);

        wr(32'h0C, 32'hFFFF_FFFE);
        wr(32'h14, 32'h1);
        rd_chk(32'h0C, 32'hFFFF_FFFE, "wrap_0");
        rd_chk(32'h0C, 32'hFFFF_FFFF, "wrap_1");
        rd_chk(32'h0C, 32'h0, "wrap_2");
        rd_chk(32'h14, 32'h1, "wrap_no_match");
        wr(32'h0C, 32'd7);
        rd_chk(32'h0C, 32'd7, "tcount_write_wins");
        wr(32'h14, 32'h0);
        rd_chk(32'h0C, 32'd9, "disabled_hold_0");
        rd_chk(32'h0C, 32'd9, "disabled_hold_1");

        wr(32'h00, 32'h5);
        wr(32'h0C, 32'd100);
        wr(32'h14, 32'h9);
        nop(3);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk("async_rst_led", led, 32'h0);
        chk("async_rst_irq", {31'b0, timer_irq}, 32'h0);
        nop(2);
        @(negedge clk);
        #1 rst_n = 1'b1;
        rd_chk(32'h00, 32'h0, "post_rst_led");
        rd_chk(32'h0C, 32'h0, "post_rst_tcount");
        rd_chk(32'h10, 32'hFFFF_FFFF, "post_rst_tcmp");
        rd_chk(32'h14, 32'h0, "post_rst_ctrl");
        rd_chk(32'h08, 32'h0, "post_rst_swchg");
        nop(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
